// File: rtl/wl_macc_norm_if.sv
// wl_macc_norm_if: streaming bus between the MAC-side caller and the
// post-processor. The master drives the tap flags and the MAC product.
// The slave returns the normalised pixel stream and the protocol error flag.
interface wl_macc_norm_if #(
    parameter int IW = 48,
    parameter int OW = 8
);
    logic          in_vld;
    logic          in_last;
    logic [IW-1:0] p;
    logic          out_vld;
    logic [OW-1:0] out_data;
    logic          out_sat;
    logic          err;

    modport master (
        output in_vld, in_last, p,
        input  out_vld, out_data, out_sat, err
    );

    modport slave (
        input  in_vld, in_last, p,
        output out_vld, out_data, out_sat, err
    );
endinterface

// File: rtl/wl_macc_norm.sv
// wl_macc_norm: accumulates groups of NTAP signed MAC products into one sum.
// It rounds the sum, shifts it right by SHIFT and clamps it to an OW-bit
// unsigned pixel. The caller's valid/last flags are delayed by LAT cycles so
// they line up with the product leaving the MAC.
// Optional build macro WL_MACC_NORM_ABS_EN: normalise |sum| instead of the
// signed sum, so that only overflow clamping can occur.
module wl_macc_norm #(
    parameter int LAT   = 4,
    parameter int IW    = 48,
    parameter int NTAP  = 5,
    parameter int SHIFT = 8,
    parameter int OW    = 8
) (
    input  logic              clk,
    input  logic              rst_b,
    wl_macc_norm_if.slave     bus
);
    localparam int AW = IW + $clog2(NTAP);
    // One guard bit so that the rounding offset and the absolute value cannot wrap.
    localparam int RW = AW + 1;
    localparam int CW = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam logic [CW-1:0]        C_LAST = CW'(NTAP - 1);
    localparam logic signed [RW-1:0] C_HALF = RW'(64'd1 << (SHIFT - 1));
    localparam logic signed [RW-1:0] C_MAX  = RW'((64'd1 << OW) - 64'd1);

    // Round half up, then arithmetic right shift.
    function automatic logic signed [RW-1:0] f_round(input logic signed [RW-1:0] x);
        logic signed [RW-1:0] t;
        t = x + C_HALF;
        return t >>> SHIFT;
    endfunction

    // Clamp to [0, 2^OW-1]; MSB of the result is the saturation flag.
    function automatic logic [OW:0] f_clamp(input logic signed [RW-1:0] r);
        if (r[RW-1])
            return {1'b1, {OW{1'b0}}};
        else if (r > C_MAX)
            return {1'b1, {OW{1'b1}}};
        else
            return {1'b0, r[OW-1:0]};
    endfunction

    logic w_v_d;
    logic w_l_d;

    // ---- stage p0: flag delay line, matched to the MAC latency ----
    generate
        if (LAT == 0) begin : g_nodly
            assign w_v_d = bus.in_vld;
            assign w_l_d = bus.in_vld & bus.in_last;
        end else begin : g_dly
            logic [LAT-1:0] r_vld_p0;
            logic [LAT-1:0] r_lst_p0;

            // Shift {in_vld, in_last} forward one stage per clock.
            always_ff @(posedge clk) begin
                if (!rst_b) begin
                    r_vld_p0 <= '0;
                    r_lst_p0 <= '0;
                end else begin
                    r_vld_p0[0] <= bus.in_vld;
                    r_lst_p0[0] <= bus.in_vld & bus.in_last;
                    for (int i = 1; i < LAT; i++) begin
                        r_vld_p0[i] <= r_vld_p0[i-1];
                        r_lst_p0[i] <= r_lst_p0[i-1];
                    end
                end
            end

            assign w_v_d = r_vld_p0[LAT-1];
            assign w_l_d = r_lst_p0[LAT-1];
        end
    endgenerate

    // ---- stage p1: accumulate products, detect group end ----
    logic signed [IW-1:0] w_p;
    logic signed [AW-1:0] w_p_ext;
    logic signed [AW-1:0] w_sum;
    logic signed [AW-1:0] r_acc_p1;
    logic [CW-1:0]        r_cnt_p1;
    logic                 w_at_max;
    logic                 w_end;

    assign w_p      = bus.p;
    assign w_p_ext  = AW'(w_p);
    assign w_sum    = ((r_cnt_p1 == '0) ? '0 : r_acc_p1) + w_p_ext;
    assign w_at_max = (r_cnt_p1 == C_LAST);
    assign w_end    = w_v_d & (w_l_d | w_at_max);

    // Running sum and tap count; both hold while no product is valid.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_acc_p1 <= '0;
            r_cnt_p1 <= '0;
        end else if (w_v_d) begin
            if (w_end) begin
                r_acc_p1 <= '0;
                r_cnt_p1 <= '0;
            end else begin
                r_acc_p1 <= w_sum;
                r_cnt_p1 <= r_cnt_p1 + 1'b1;
            end
        end
    end

    // ---- stage p2: normalise, clamp and register the pixel ----
    logic signed [RW-1:0] w_fin;
    logic signed [RW-1:0] w_mag;
    logic [OW:0]          w_norm;

    assign w_fin = RW'(w_sum);
`ifdef WL_MACC_NORM_ABS_EN
    assign w_mag = w_fin[RW-1] ? -w_fin : w_fin;
`else
    assign w_mag = w_fin;
`endif
    assign w_norm = f_clamp(f_round(w_mag));

    logic          r_out_vld_p2;
    logic [OW-1:0] r_out_data_p2;
    logic          r_out_sat_p2;
    logic          r_err;

    // Output pulse on group end; data and sat hold between pulses.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_out_vld_p2  <= 1'b0;
            r_out_data_p2 <= '0;
            r_out_sat_p2  <= 1'b0;
        end else begin
            r_out_vld_p2 <= w_end;
            if (w_end) begin
                r_out_sat_p2  <= w_norm[OW];
                r_out_data_p2 <= w_norm[OW-1:0];
            end
        end
    end

    // Sticky error: last flag and tap count disagree (short or long group).
    always_ff @(posedge clk) begin
        if (!rst_b)
            r_err <= 1'b0;
        else if (w_v_d && (w_l_d != w_at_max))
            r_err <= 1'b1;
    end

    assign bus.out_vld  = r_out_vld_p2;
    assign bus.out_data = r_out_data_p2;
    assign bus.out_sat  = r_out_sat_p2;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_wl_macc_norm.sv
// tb_wl_macc_norm: randomized and directed bench for wl_macc_norm with a
// group-level reference model. It honours WL_MACC_NORM_ABS_EN when defined.
module tb_wl_macc_norm;
    localparam int LAT   = 4;
    localparam int IW    = 48;
    localparam int NTAP  = 5;
    localparam int SHIFT = 8;
    localparam int OW    = 8;
    localparam int PI    = (LAT > 0) ? LAT - 1 : 0;

    typedef struct {
        int            c;
        logic [OW-1:0] d;
        logic          s;
    } ev_t;

    logic clk = 1'b0;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    wl_macc_norm_if #(.IW(IW), .OW(OW)) bus ();

    wl_macc_norm #(.LAT(LAT), .IW(IW), .NTAP(NTAP), .SHIFT(SHIFT), .OW(OW)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    // MAC stand-in: the product leaves LAT cycles after its flags are sampled.
    logic [IW-1:0] tap_p;
    logic [IW-1:0] p_dly [0:PI];
    always @(posedge clk) begin
        p_dly[0] <= tap_p;
        for (int i = 1; i < LAT; i++) p_dly[i] <= p_dly[i-1];
    end
    assign bus.p = (LAT == 0) ? tap_p : p_dly[PI];

    always @(posedge clk) cyc <= cyc + 1;

    ev_t exp_q[$];
    ev_t obs_q[$];

    // Record every output pulse with the cycle it appeared in.
    always @(negedge clk) begin
        if (bus.out_vld === 1'b1) obs_q.push_back('{cyc, bus.out_data, bus.out_sat});
    end

    // Reference model state: group-level sum, tap count, error flag.
    longint m_sum;
    int     m_cnt;
    logic   m_err;

    function automatic void pixel_of(input longint s, output logic [OW-1:0] d, output logic sat);
        longint v;
        longint r;
        longint mx;
        v = s;
`ifdef WL_MACC_NORM_ABS_EN
        if (v < 0) v = -v;
`endif
        r  = (v + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        mx = (longint'(1) <<< OW) - 1;
        if (r < 0) begin
            d = '0; sat = 1'b1;
        end else if (r > mx) begin
            d = mx[OW-1:0]; sat = 1'b1;
        end else begin
            d = r[OW-1:0]; sat = 1'b0;
        end
    endfunction

    function automatic longint rand_prod(input bit big);
        longint x;
        if (big) begin
            x = longint'({$urandom(), $urandom()});
            x = (x <<< (64 - IW)) >>> (64 - IW);
        end else begin
            x = longint'($urandom_range(40000, 0)) - 8000;
        end
        return x;
    endfunction

    // Present one cycle of flags (and product for the MAC); update the model.
    task automatic tap(input bit v, input bit l, input longint pv);
        logic [OW-1:0] d;
        logic          s;
        longint        sum;
        bus.in_vld  = v;
        bus.in_last = l;
        tap_p       = v ? pv[IW-1:0] : IW'({$urandom(), $urandom()});
        @(posedge clk);
        #1;
        if (v) begin
            sum = m_sum + pv;
            if (l || m_cnt == NTAP - 1) begin
                if (l != (m_cnt == NTAP - 1)) m_err = 1'b1;
                pixel_of(sum, d, s);
                exp_q.push_back('{cyc + LAT, d, s});
                m_sum = 0;
                m_cnt = 0;
            end else begin
                m_sum = sum;
                m_cnt++;
            end
        end
        bus.in_vld  = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tap(1'b0, 1'b0, 0);
    endtask

    task automatic start_scn();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        bus.in_vld  = 1'b0;
        bus.in_last = 1'b0;
        tap_p       = '0;
        rst_b       = 1'b0;
        m_sum = 0; m_cnt = 0; m_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", bus.out_vld); end
        total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_data: got %0d want 0", bus.out_data); end
        total++; if (bus.out_sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b want 0", bus.out_sat); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        rst_b = 1'b1;
        start_scn();
        idle(LAT + 6);
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL reset_noflag: got %0d pulses want 0", obs_q.size()); end
    endtask

    task automatic test_basic();
        start_scn();
        tap(1, 0, 100); tap(1, 0, 200); tap(1, 0, 300); tap(1, 0, 400); tap(1, 1, 0);
        idle(LAT + 4);
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].d !== exp_q[i].d || obs_q[i].s !== exp_q[i].s) begin
                bad++;
                $display("FAIL basic_out%0d: got cyc=%0d data=%0d sat=%b want cyc=%0d data=%0d sat=%b",
                         i, obs_q[i].c, obs_q[i].d, obs_q[i].s, exp_q[i].c, exp_q[i].d, exp_q[i].s);
            end
        end
        if (obs_q.size() > 0) begin
            total++;
            if (obs_q[0].d !== 8'd4 || obs_q[0].s !== 1'b0) begin
                bad++; $display("FAIL basic_value: got data=%0d sat=%b want data=4 sat=0", obs_q[0].d, obs_q[0].s);
            end
        end
        total++;
        if (bus.out_data !== 8'd4 || bus.out_vld !== 1'b0) begin
            bad++; $display("FAIL basic_hold: got data=%0d vld=%b want data=4 vld=0", bus.out_data, bus.out_vld);
        end
    endtask

    task automatic test_sat();
        start_scn();
        repeat (4) tap(1, 0, 14000);
        tap(1, 1, 14000);
        repeat (4) tap(1, 0, -100);
        tap(1, 1, -100);
        idle(LAT + 4);
        total++;
        if (obs_q.size() != 2) begin bad++; $display("FAIL sat_count: got %0d want 2", obs_q.size()); end
        else begin
            total++;
            if (obs_q[0].d !== 8'd255 || obs_q[0].s !== 1'b1 || obs_q[0].c !== exp_q[0].c) begin
                bad++; $display("FAIL sat_pos: got data=%0d sat=%b cyc=%0d want data=255 sat=1 cyc=%0d",
                                obs_q[0].d, obs_q[0].s, obs_q[0].c, exp_q[0].c);
            end
            total++;
`ifdef WL_MACC_NORM_ABS_EN
            if (obs_q[1].d !== 8'd2 || obs_q[1].s !== 1'b0) begin
                bad++; $display("FAIL sat_neg: got data=%0d sat=%b want data=2 sat=0", obs_q[1].d, obs_q[1].s);
            end
`else
            if (obs_q[1].d !== 8'd0 || obs_q[1].s !== 1'b1) begin
                bad++; $display("FAIL sat_neg: got data=%0d sat=%b want data=0 sat=1", obs_q[1].d, obs_q[1].s);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        start_scn();
        tap(1, 0, 100); tap(1, 0, 200); tap(1, 0, 300); tap(1, 0, 400); tap(1, 1, 0);
        repeat (4) tap(1, 0, 512);
        tap(1, 1, 512);
        tap(1, 0, rand_prod(0)); tap(1, 0, rand_prod(0));
        idle(2);
        tap(1, 0, rand_prod(0)); tap(1, 0, rand_prod(0)); tap(1, 1, rand_prod(0));
        idle(LAT + 4);
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].d !== exp_q[i].d || obs_q[i].s !== exp_q[i].s) begin
                bad++;
                $display("FAIL b2b_out%0d: got cyc=%0d data=%0d sat=%b want cyc=%0d data=%0d sat=%b",
                         i, obs_q[i].c, obs_q[i].d, obs_q[i].s, exp_q[i].c, exp_q[i].d, exp_q[i].s);
            end
        end
        if (obs_q.size() >= 2) begin
            total++;
            if (obs_q[0].d !== 8'd4 || obs_q[1].d !== 8'd10 || obs_q[1].c - obs_q[0].c != NTAP) begin
                bad++; $display("FAIL b2b_pair: got %0d,%0d spacing %0d want 4,10 spacing %0d",
                                obs_q[0].d, obs_q[1].d, obs_q[1].c - obs_q[0].c, NTAP);
            end
        end
    endtask

    task automatic test_random();
        start_scn();
        for (int g = 0; g < 24; g++) begin
            bit big;
            big = ($urandom_range(3, 0) == 0);
            for (int t = 0; t < NTAP; t++) begin
                tap(1, (t == NTAP - 1), rand_prod(big));
                if ($urandom_range(4, 0) == 0) idle($urandom_range(3, 1));
            end
        end
        idle(LAT + 4);
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].d !== exp_q[i].d || obs_q[i].s !== exp_q[i].s) begin
                bad++;
                $display("FAIL rand_out%0d: got cyc=%0d data=%0d sat=%b want cyc=%0d data=%0d sat=%b",
                         i, obs_q[i].c, obs_q[i].d, obs_q[i].s, exp_q[i].c, exp_q[i].d, exp_q[i].s);
            end
        end
        total++;
        if (bus.err !== m_err) begin bad++; $display("FAIL rand_err: got %b want %b", bus.err, m_err); end
    endtask

    task automatic test_err();
        start_scn();
        tap(1, 0, 256); tap(1, 0, 256); tap(1, 1, 256);
        idle(LAT + 2);
        total++;
        if (bus.err !== 1'b1 || bus.out_data !== 8'd3) begin
            bad++; $display("FAIL err_short: got err=%b data=%0d want err=1 data=3", bus.err, bus.out_data);
        end
        repeat (5) tap(1, 0, 100);
        tap(1, 0, 1000);
        repeat (3) tap(1, 0, 200);
        tap(1, 1, 200);
        idle(LAT + 4);
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL err_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].d !== exp_q[i].d || obs_q[i].s !== exp_q[i].s) begin
                bad++;
                $display("FAIL err_out%0d: got cyc=%0d data=%0d sat=%b want cyc=%0d data=%0d sat=%b",
                         i, obs_q[i].c, obs_q[i].d, obs_q[i].s, exp_q[i].c, exp_q[i].d, exp_q[i].s);
            end
        end
        total++;
        if (bus.err !== m_err) begin bad++; $display("FAIL err_sticky: got %b want %b", bus.err, m_err); end
    endtask

    task automatic test_mid_reset();
        start_scn();
        tap(1, 0, 5000); tap(1, 0, 5000);
        rst_b = 1'b0;
        idle(1);
        rst_b = 1'b1;
        m_sum = 0; m_cnt = 0; m_err = 1'b0;
        total++;
        if (bus.out_vld !== 1'b0 || bus.out_data !== '0 || bus.out_sat !== 1'b0 || bus.err !== 1'b0) begin
            bad++; $display("FAIL mrst_zero: got vld=%b data=%0d sat=%b err=%b want all 0",
                            bus.out_vld, bus.out_data, bus.out_sat, bus.err);
        end
        idle(LAT + 4);
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL mrst_discard: got %0d pulses want 0", obs_q.size()); end
        tap(1, 0, 100); tap(1, 0, 200); tap(1, 0, 300); tap(1, 0, 400); tap(1, 1, 0);
        idle(LAT + 4);
        total++;
        if (obs_q.size() != 1) begin bad++; $display("FAIL mrst_count: got %0d want 1", obs_q.size()); end
        else begin
            total++;
            if (obs_q[0].d !== 8'd4 || obs_q[0].s !== 1'b0 || obs_q[0].c !== exp_q[0].c) begin
                bad++; $display("FAIL mrst_next: got data=%0d sat=%b cyc=%0d want data=4 sat=0 cyc=%0d",
                                obs_q[0].d, obs_q[0].s, obs_q[0].c, exp_q[0].c);
            end
        end
        total++;
        if (bus.err !== 1'b0) begin bad++; $display("FAIL mrst_err: got %b want 0", bus.err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat();
        test_back_to_back();
        test_random();
        test_err();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wl_macc_norm.md
# wl_macc_norm

Streaming post-processor sitting directly downstream of the pre-add DSP48 MAC in the filter datapath. Consumes the MAC's signed product stream, accumulates a group of NTAP tap products into one filter output, then applies rounding, normalisation shift and clamping to an OW-bit unsigned pixel. Re-times the caller's input-side valid/last flags by the MAC latency so the two stay aligned.

## Interface
- LAT, 4: MAC pipeline latency in cycles (0-4); must equal the MAC's LATENCY.
- IW, 48: MAC product width, two's complement.
- NTAP, 5: products per output group (2-64).
- SHIFT, 8: normalisation right-shift (1-24).
- OW, 8: output pixel width (1-16).
- clk  in  1  clock; all logic on rising edge.
- rst_b  in  1  reset, synchronous, active-low.
- in_vld  in  1  high in the cycle a/b/d are presented to the MAC.
- in_last  in  1  qualified by in_vld; marks the final tap of a group.
- p  in  IW  MAC product; valid LAT cycles after the matching in_vld.
- out_vld  out  1  one-cycle pulse, result on out_data.
- out_data  out  OW  normalised, clamped pixel.
- out_sat  out  1  qualified by out_vld; clamping occurred.
- err  out  1  sticky group-length protocol error.

## Operation
- Flag delay line: LAT-stage shift register carrying {in_vld, in_last} -> {v_d, l_d}; LAT=0 means combinational pass-through.
- Accumulator width AW = IW + clog2(NTAP); p sign-extended to AW.
- Tap counter cnt, 0..NTAP-1. State is implicit: cnt==0 is IDLE/FIRST, cnt>0 is ACCUM.
- On v_d: sum = (cnt==0 ? 0 : acc) + p.
- Group ends when v_d and (l_d or cnt==NTAP-1). On end: acc<=0, cnt<=0, final = sum. Otherwise acc<=sum, cnt<=cnt+1.
- Normalise final: r = (final + 2^(SHIFT-1)) >>> SHIFT (arithmetic).
- Clamp: r<0 -> 0, sat=1; r>2^OW-1 -> 2^OW-1, sat=1; else r, sat=0.
- err set (sticky until reset) when:
  - l_d arrives with cnt != NTAP-1 (short group; output still produced), or
  - cnt==NTAP-1 without l_d (long group; forced end, output produced, next product starts a new group).
- v_d low: acc and cnt hold. Gaps inside a group are legal.
- No backpressure. The MAC runs with CE tied high and downstream must accept every out_vld.

## Timing
- Reset values: out_vld=0, out_data=0, out_sat=0, err=0, acc=0, cnt=0, delay line all 0.
- Reset mid-group discards the partial group and all in-flight flags. Products arriving after reset with no flag produce no output.
- out_vld, out_data and out_sat are registered. out_vld rises 1 cycle after the final product's cycle, i.e. LAT+1 cycles after the in_vld/in_last sample of the last tap.
- out_data and out_sat hold their values between pulses.
- Back-to-back groups are allowed: the first tap of group N+1 on the cycle after the last tap of group N gives full throughput of 1 output per NTAP cycles.
- NTAP=1 in protocol terms: every v_d ends a group.

## Configuration
- WL_MACC_NORM_ABS_EN defined: final is replaced by |final| before rounding, for gradient-magnitude use. The negative clamp cannot occur; out_sat reports overflow only.
- Undefined: signed rounding, with negatives clamped to 0 and out_sat=1.

## Test plan
- Defaults, products 100,200,300,400,0 with in_last on tap 5 -> out_data=4 ((1000+128)>>8), out_sat=0, out_vld exactly LAT+1=5 cycles after the last in_vld.
- Products summing to 70000 -> out_data=255, out_sat=1.
- Products summing to -500 -> out_data=0, out_sat=1. With WL_MACC_NORM_ABS_EN -> out_data=2, out_sat=0.
- Two back-to-back groups (sums 1000, 2560) with no gap, plus a third group with 2 idle cycles mid-group -> outputs 4, 10, correct, with out_vld spaced 5 cycles for the first two.
- in_last on tap 3 (sum 768) -> out_data=3, err=1 and stays 1. Next 6-tap group without in_last -> forced output after tap 5, 6th product starts a new group.
- rst_b low for 1 cycle after tap 2 of a group -> no output for that group, all outputs 0, the next full group is correct.
